fifo_rd_stream: RTL and testbench

//  Read-side adapter on the rdclk side of the async FIFO. Drives the FIFO rd strobe,

---
 rtl/fifo_rd_stream.sv | 106 ++++++++++
 tb/tb_fifo_rd_stream.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_stream.sv
// Read-side adapter for the async FIFO: issues rd strobes, absorbs the RAM read latency in a
// small skid buffer and presents popped words on a registered valid/ready stream.
module fifo_rd_stream #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned RD_LATENCY = 1,
  parameter int unsigned CNTW       = 16
) (
  input  logic             rdclk,
  input  logic             reset,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_dataout,
  output logic             fifo_rd,
  output logic             m_valid,
  output logic [WIDTH-1:0] m_data,
  input  logic             m_ready,
  output logic [CNTW-1:0]  word_cnt,
  output logic             busy
);

  localparam int unsigned BufDepth = RD_LATENCY + 1;
  localparam int unsigned PtrW     = $clog2(BufDepth);
  localparam int unsigned OccW     = $clog2(BufDepth + 1);
  localparam int unsigned TotW     = $clog2(BufDepth + RD_LATENCY + 1);

  logic [WIDTH-1:0]      buf_q [BufDepth];
  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [OccW-1:0]       occ_q, occ_d;
  logic [RD_LATENCY-1:0] inflight_q, inflight_d;
  logic                  m_valid_q, m_valid_d;
  logic [WIDTH-1:0]      m_data_q, m_data_d;
  logic [CNTW-1:0]       word_cnt_q, word_cnt_d;
  logic [TotW-1:0]       total;
  logic                  push, pop, head_from_pipe;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(BufDepth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign push = inflight_q[RD_LATENCY-1];
  assign pop  = m_valid_q & m_ready;

  always_comb begin
    total = TotW'(occ_q);
    for (int i = 0; i < int'(RD_LATENCY); i++) begin
      total = total + TotW'(inflight_q[i]);
    end
  end

  // Only issue a read when a slot is guaranteed for it on arrival, so the buffer cannot overflow.
  assign fifo_rd = reset & ~fifo_empty & ((total < TotW'(BufDepth)) | pop);

  // The arriving word becomes the head when nothing older remains after this cycle's pop.
  assign head_from_pipe = push & ((occ_q == '0) | (pop & (occ_q == OccW'(1))));

  always_comb begin
    inflight_d    = inflight_q << 1;
    inflight_d[0] = fifo_rd;

    occ_d = occ_q;
    if (push && !pop) begin
      occ_d = occ_q + OccW'(1);
    end else if (pop && !push) begin
      occ_d = occ_q - OccW'(1);
    end

    wr_ptr_d   = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d   = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    word_cnt_d = word_cnt_q + CNTW'(pop);

    m_valid_d = (occ_d != '0);
    m_data_d  = m_data_q;
    if (occ_d != '0) begin
      m_data_d = head_from_pipe ? fifo_dataout : buf_q[rd_ptr_d];
    end
  end

  always_ff @(posedge rdclk) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      occ_q      <= '0;
      inflight_q <= '0;
      m_valid_q  <= 1'b0;
      m_data_q   <= '0;
      word_cnt_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      occ_q      <= occ_d;
      inflight_q <= inflight_d;
      m_valid_q  <= m_valid_d;
      m_data_q   <= m_data_d;
      word_cnt_q <= word_cnt_d;
      if (push) begin
        buf_q[wr_ptr_q] <= fifo_dataout;
      end
    end
  end

  assign m_valid  = m_valid_q;
  assign m_data   = m_data_q;
  assign word_cnt = word_cnt_q;
  assign busy     = (occ_q != '0) | (|inflight_q);

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: two instances (RD_LATENCY=1/CNTW=16, RD_LATENCY=2/CNTW=4) fed from
// behavioural FIFO models, with a scoreboard of expected words per instance.
module tb_fifo_rd_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        m_ready;
  logic        fifo_empty0, fifo_empty1;
  logic        fifo_rd0, fifo_rd1;
  logic [7:0]  dout0 = 8'hEE, stage1 = 8'hEE, dout1 = 8'hEE;
  logic        m_valid0, m_valid1;
  logic [7:0]  m_data0, m_data1;
  logic [15:0] word_cnt0;
  logic [3:0]  word_cnt1;
  logic        busy0, busy1;

  fifo_rd_stream #(.WIDTH(8), .RD_LATENCY(1), .CNTW(16)) u_dut_l1 (
    .rdclk(clk), .reset(reset), .fifo_empty(fifo_empty0), .fifo_dataout(dout0),
    .fifo_rd(fifo_rd0), .m_valid(m_valid0), .m_data(m_data0), .m_ready(m_ready),
    .word_cnt(word_cnt0), .busy(busy0)
  );

  fifo_rd_stream #(.WIDTH(8), .RD_LATENCY(2), .CNTW(4)) u_dut_l2 (
    .rdclk(clk), .reset(reset), .fifo_empty(fifo_empty1), .fifo_dataout(dout1),
    .fifo_rd(fifo_rd1), .m_valid(m_valid1), .m_data(m_data1), .m_ready(m_ready),
    .word_cnt(word_cnt1), .busy(busy1)
  );

  // Behavioural source FIFOs; unread cycles drive a marker so bogus captures show up.
  logic [7:0] src0 [256];
  logic [7:0] src1 [256];
  int wr0 = 0, wr1 = 0, rd0 = 0, rd1 = 0;
  assign fifo_empty0 = (rd0 == wr0);
  assign fifo_empty1 = (rd1 == wr1);

  always @(posedge clk) begin
    if (fifo_rd0) begin
      dout0 <= src0[rd0[7:0]];
      rd0   <= rd0 + 1;
    end else begin
      dout0 <= 8'hEE;
    end
    if (fifo_rd1) begin
      stage1 <= src1[rd1[7:0]];
      rd1    <= rd1 + 1;
    end else begin
      stage1 <= 8'hEE;
    end
    dout1 <= stage1;
  end

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  logic [7:0] exp0[$];
  logic [7:0] exp1[$];
  logic       hold0_q = 1'b0, hold1_q = 1'b0;
  logic [7:0] hd0_q, hd1_q;

  // Scoreboard, stream-stability and read-while-empty monitors, sampled mid-cycle.
  always @(negedge clk) begin
    if (reset && m_ready && m_valid0) begin
      if (exp0.size() == 0) check("stale_word0", 32'd1, 32'd0);
      else check("data0", {24'd0, m_data0}, {24'd0, exp0.pop_front()});
    end
    if (reset && m_ready && m_valid1) begin
      if (exp1.size() == 0) check("stale_word1", 32'd1, 32'd0);
      else check("data1", {24'd0, m_data1}, {24'd0, exp1.pop_front()});
    end
    if (hold0_q && reset) begin
      check("hold_valid0", {31'd0, m_valid0}, 32'd1);
      check("hold_data0", {24'd0, m_data0}, {24'd0, hd0_q});
    end
    if (hold1_q && reset) begin
      check("hold_valid1", {31'd0, m_valid1}, 32'd1);
      check("hold_data1", {24'd0, m_data1}, {24'd0, hd1_q});
    end
    if (fifo_rd0) check("rd_while_empty0", {31'd0, fifo_empty0}, 32'd0);
    if (fifo_rd1) check("rd_while_empty1", {31'd0, fifo_empty1}, 32'd0);
    hold0_q <= m_valid0 & ~m_ready & reset;
    hold1_q <= m_valid1 & ~m_ready & reset;
    hd0_q   <= m_data0;
    hd1_q   <= m_data1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [7:0] base, input int n);
    logic [7:0] w;
    for (int i = 0; i < n; i++) begin
      w = base + 8'(i);
      src0[wr0[7:0]] = w;
      src1[wr1[7:0]] = w;
      wr0++;
      wr1++;
      exp0.push_back(w);
      exp1.push_back(w);
    end
  endtask

  // mode 0: ready held high, 1: toggling, 2: random.
  task automatic drain(input int mode, input int max_cyc);
    int   c;
    logic tog;
    c   = 0;
    tog = 1'b1;
    while (!(exp0.size() == 0 && exp1.size() == 0 && !busy0 && !busy1) && c < max_cyc) begin
      case (mode)
        0:       m_ready = 1'b1;
        1:       begin m_ready = tog; tog = ~tog; end
        default: m_ready = 1'($urandom_range(0, 1));
      endcase
      tick();
      c++;
    end
    m_ready = 1'b1;
    check("drain_done", {31'd0, c < max_cyc}, 32'd1);
  endtask

  typedef struct {
    int          n;
    logic [7:0]  base;
    int          mode;
    logic [15:0] exp_cnt0;
    logic [3:0]  exp_cnt1;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int t_rd0, t_rd1, t_v0, t_v1, n_rd0, n_rd1, nval;

    vecs[0] = '{17, 8'h80, 0, 16'd17, 4'd1};
    vecs[1] = '{16, 8'h30, 1, 16'd33, 4'd1};
    vecs[2] = '{5,  8'h50, 2, 16'd38, 4'd6};
    vecs[3] = '{20, 8'h60, 0, 16'd58, 4'd10};
    vecs[4] = '{3,  8'hA0, 1, 16'd61, 4'd13};

    // Reset held with data available: no reads, outputs idle.
    reset   = 1'b0;
    m_ready = 1'b0;
    load(8'h01, 4);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("rst_rd0", {31'd0, fifo_rd0}, 32'd0);
      check("rst_rd1", {31'd0, fifo_rd1}, 32'd0);
      check("rst_valid0", {31'd0, m_valid0}, 32'd0);
      check("rst_valid1", {31'd0, m_valid1}, 32'd0);
      check("rst_cnt0", {16'd0, word_cnt0}, 32'd0);
      check("rst_cnt1", {28'd0, word_cnt1}, 32'd0);
      check("rst_busy0", {31'd0, busy0}, 32'd0);
      check("rst_busy1", {31'd0, busy1}, 32'd0);
    end
    wr0 = rd0;
    wr1 = rd1;
    exp0.delete();
    exp1.delete();
    tick();
    reset   = 1'b1;
    m_ready = 1'b1;

    // Streaming with latency measurement.
    load(8'h11, 8);
    t_rd0 = -1; t_rd1 = -1; t_v0 = -1; t_v1 = -1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (fifo_rd0 && t_rd0 < 0) t_rd0 = c;
      if (fifo_rd1 && t_rd1 < 0) t_rd1 = c;
      if (m_valid0 && t_v0 < 0) t_v0 = c;
      if (m_valid1 && t_v1 < 0) t_v1 = c;
    end
    check("first_rd0", {31'd0, t_rd0 == 0}, 32'd1);
    check("latency0", t_v0 - t_rd0, 32'd2);
    check("latency1", t_v1 - t_rd1, 32'd3);
    check("stream_cnt0", {16'd0, word_cnt0}, 32'd8);
    check("stream_cnt1", {28'd0, word_cnt1}, 32'd8);
    check("stream_left0", exp0.size(), 32'd0);
    check("stream_left1", exp1.size(), 32'd0);

    // Backpressure: reads stop once the skid buffer is committed.
    tick();
    m_ready = 1'b0;
    load(8'h21, 5);
    n_rd0 = 0; n_rd1 = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      n_rd0 += int'(fifo_rd0);
      n_rd1 += int'(fifo_rd1);
    end
    check("bp_pulses0", n_rd0, 32'd2);
    check("bp_pulses1", n_rd1, 32'd3);
    check("bp_valid0", {31'd0, m_valid0}, 32'd1);
    check("bp_valid1", {31'd0, m_valid1}, 32'd1);
    check("bp_head0", {24'd0, m_data0}, 32'h21);
    check("bp_head1", {24'd0, m_data1}, 32'h21);
    check("bp_rd_off0", {31'd0, fifo_rd0}, 32'd0);
    check("bp_rd_off1", {31'd0, fifo_rd1}, 32'd0);
    tick();
    drain(0, 100);
    check("bp_cnt0", {16'd0, word_cnt0}, 32'd13);
    check("bp_cnt1", {28'd0, word_cnt1}, 32'd13);

    // Reset mid-stream with words buffered and in flight.
    m_ready = 1'b0;
    load(8'hC1, 4);
    repeat (8) tick();
    check("pre_rst_busy0", {31'd0, busy0}, 32'd1);
    check("pre_rst_busy1", {31'd0, busy1}, 32'd1);
    reset = 1'b0;
    wr0 = rd0;
    wr1 = rd1;
    exp0.delete();
    exp1.delete();
    tick();
    check("mid_rst_valid0", {31'd0, m_valid0}, 32'd0);
    check("mid_rst_valid1", {31'd0, m_valid1}, 32'd0);
    check("mid_rst_busy0", {31'd0, busy0}, 32'd0);
    check("mid_rst_busy1", {31'd0, busy1}, 32'd0);
    check("mid_rst_cnt0", {16'd0, word_cnt0}, 32'd0);
    reset   = 1'b1;
    m_ready = 1'b1;
    nval    = 0;
    repeat (10) begin
      @(negedge clk);
      if (m_valid0 || m_valid1) nval++;
    end
    check("post_rst_quiet", nval, 32'd0);
    tick();

    // Table-driven transfers; counts accumulate from the reset above.
    for (int v = 0; v < 5; v++) begin
      load(vecs[v].base, vecs[v].n);
      drain(vecs[v].mode, 400);
      check($sformatf("vec%0d_cnt0", v), {16'd0, word_cnt0}, {16'd0, vecs[v].exp_cnt0});
      check($sformatf("vec%0d_cnt1", v), {28'd0, word_cnt1}, {28'd0, vecs[v].exp_cnt1});
      check($sformatf("vec%0d_busy0", v), {31'd0, busy0}, 32'd0);
      check($sformatf("vec%0d_busy1", v), {31'd0, busy1}, 32'd0);
      check($sformatf("vec%0d_valid0", v), {31'd0, m_valid0}, 32'd0);
      check($sformatf("vec%0d_valid1", v), {31'd0, m_valid1}, 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, want completion");
    $fatal(1, "timeout");
  end

endmodule
